// File: rtl/por_reset_sequencer_pkg.sv
// Shared state encodings and constants for the POR reset sequencer.
// Imported by the sequencer top level.
package por_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD    = 3'd0,
        ST_FILTER  = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_SWRST   = 3'd4
    } seq_state_e;

    localparam logic [7:0] GLITCH_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == GLITCH_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/por_reset_sequencer_sync_chain.sv
// Flop chain bringing the asynchronous POR level into the clock domain.
// Cleared synchronously so a block reset forces a full refill.
module por_sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/por_reset_sequencer.sv
// Filters the synchronized POR level and releases domain resets in order.
// Also handles warm resets and counts aborted filter windows.
module por_reset_sequencer
    import por_reset_sequencer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 16,
    parameter int unsigned STAGE_DELAY   = 8,
    parameter int unsigned NUM_DOMAINS   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   porb_l,
    input  logic                   sw_reset_req,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   por_done,
    output logic [2:0]             seq_state,
    output logic [7:0]             glitch_cnt
);

    logic                   pgood;
    seq_state_e             state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [2:0]             dom_q, dom_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic                   done_q, done_d;
    logic [7:0]             glitch_q, glitch_d;

    por_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (porb_l),
        .sync_o  (pgood)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dom_d    = dom_q;
        rst_d    = rst_q;
        done_d   = done_q;
        glitch_d = glitch_q;
        if (!pgood && state_q inside {ST_RELEASE, ST_RUN, ST_SWRST}) begin
            // Brown-out: drop everything but do not count it as a glitch
            state_d = ST_HOLD;
            cnt_d   = '0;
            rst_d   = '1;
            done_d  = 1'b0;
        end else if (sw_reset_req && state_q inside {ST_RELEASE, ST_RUN}) begin
            state_d = ST_SWRST;
            cnt_d   = 8'd1;
            rst_d   = '1;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    rst_d  = '1;
                    done_d = 1'b0;
                    if (pgood) begin
                        state_d = ST_FILTER;
                        cnt_d   = 8'd1;
                    end
                end
                ST_FILTER: begin
                    if (!pgood) begin
                        state_d  = ST_HOLD;
                        cnt_d    = '0;
                        glitch_d = sat_inc(glitch_q);
                    end else if (cnt_q == 8'(FILTER_CYCLES)) begin
                        state_d = ST_RELEASE;
                        dom_d   = '0;
                        cnt_d   = 8'd1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == 8'(STAGE_DELAY)) begin
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            if (dom_q == 3'(i)) rst_d[i] = 1'b0;
                        end
                        cnt_d = 8'd1;
                        if (dom_q == 3'(NUM_DOMAINS - 1)) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            dom_d = dom_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    rst_d  = '0;
                    done_d = 1'b1;
                end
                ST_SWRST: begin
                    rst_d  = '1;
                    done_d = 1'b0;
                    if (cnt_q == 8'(STAGE_DELAY)) begin
                        state_d = ST_RELEASE;
                        dom_d   = '0;
                        cnt_d   = 8'd1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    rst_d   = '1;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_HOLD;
            cnt_q    <= '0;
            dom_q    <= '0;
            rst_q    <= '1;
            done_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dom_q    <= dom_d;
            rst_q    <= rst_d;
            done_q   <= done_d;
            glitch_q <= glitch_d;
        end
    end

    assign rst_out    = rst_q;
    assign por_done   = done_q;
    assign seq_state  = state_q;
    assign glitch_cnt = glitch_q;

endmodule

// File: doc/por_reset_sequencer.md
Name: por_reset_sequencer

Overview:
- Consumer end of the power-on-reset interface: takes the raw active-low POR level `porb_l` and produces ordered, glitch-filtered, clock-synchronous reset releases for NUM_DOMAINS downstream domains (housekeeping, core, user area).
- Sits in the 1.8V clocked domain next to the clocking block.
- Also supports a software-requested warm reset and reports sequencing status.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on `porb_l`; minimum 2.
- FILTER_CYCLES, 16, consecutive synchronized-high cycles required before release starts; range 1..255.
- STAGE_DELAY, 8, cycles between successive domain releases; range 1..255.
- NUM_DOMAINS, 3, number of reset outputs; range 1..8.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high block reset.
- porb_l  input  1  asynchronous POR level, low = power not good.
- sw_reset_req  input  1  single-cycle warm-reset request.
- rst_out  output  NUM_DOMAINS  active-high domain resets, bit 0 released first.
- por_done  output  1  high once all domains are released.
- seq_state  output  3  current FSM state encoding.
- glitch_cnt  output  8  saturating count of filter aborts.

Behaviour:
- Interface decision: one clock (`clock`); `reset` is synchronous and active-high.
- While `reset` is high, at each edge:
  - sync chain cleared to 0;
  - state = HOLD;
  - counters cleared;
  - rst_out = all 1; por_done = 0; glitch_cnt = 0.
- `porb_l` passes through SYNC_STAGES flops to produce `pgood`. There is no other use of raw `porb_l`.
- All outputs are registered.
- FSM states and encodings:
  - HOLD (0): all rst_out = 1. If pgood = 1, go to FILTER with cnt = 1.
  - FILTER (1): cnt increments while pgood = 1.
    - When cnt == FILTER_CYCLES, go to RELEASE with dom = 0 and cnt = 1.
    - If pgood = 0, go to HOLD; glitch_cnt += 1, saturating at 255.
  - RELEASE (2): when cnt == STAGE_DELAY, clear rst_out[dom], then dom += 1 and cnt = 1.
    - After the release of dom = NUM_DOMAINS-1, go to RUN and set por_done = 1 at that same edge.
  - RUN (3): steady state. rst_out = 0, por_done = 1.
  - SWRST (4): all rst_out = 1, por_done = 0. After STAGE_DELAY cycles, go to RELEASE with dom = 0 and cnt = 1.
- pgood = 0 in RELEASE, RUN or SWRST:
  - next edge: state = HOLD, all rst_out = 1, por_done = 0;
  - glitch_cnt is not incremented (this is a brown-out, not a glitch).
- sw_reset_req:
  - honoured only in RUN or RELEASE; it moves the FSM to SWRST and asserts all rst_out at the next edge;
  - ignored in HOLD, FILTER and SWRST.
- Simultaneous pgood = 0 and sw_reset_req: pgood wins and the FSM goes to HOLD.
- Timing from the first edge t0 at which pgood is sampled high, with no aborts:
  - rst_out[i] falls at edge t0 + FILTER_CYCLES + (i+1)*STAGE_DELAY;
  - por_done rises with the last domain release.
- rst_out bits are monotonic during sequencing: once released, a bit stays 0 until a full reassert.

Decomposition:
- Shared package/include holds:
  - state localparams ST_HOLD=3'd0, ST_FILTER=3'd1, ST_RELEASE=3'd2, ST_RUN=3'd3, ST_SWRST=3'd4;
  - GLITCH_MAX=8'd255.
- Sub-module `por_sync_chain` (parameter STAGES): a plain flop chain with synchronous clear driven by `reset`.
- The top level contains the FSM, the cycle counter, the domain index and glitch_cnt.

Test Plan:
- Clean power-up (default parameters; `porb_l` rises so that pgood is first high at edge 2):
  - rst_out = 3'b111 until edge 26;
  - then 3'b110 at 26, 3'b100 at 34, 3'b000 at 42;
  - por_done rises at edge 42.
- Glitch filtering: pulse `porb_l` high for 10 cycles, low for 3, then hold high.
  - rst_out stays 3'b111 through the glitch; glitch_cnt = 1.
  - Release begins FILTER_CYCLES after the second pgood rise.
- Brown-out in RUN: drop `porb_l` low.
  - Exactly SYNC_STAGES+1 edges later: rst_out = 3'b111, por_done = 0, seq_state = 0.
  - glitch_cnt is unchanged.
- Warm reset: pulse sw_reset_req in RUN.
  - Next edge: rst_out = 3'b111, seq_state = 4.
  - Releases at +16, +24 and +32 edges after the pulse; por_done again at +32.
- Collisions:
  - sw_reset_req coincident with pgood falling gives HOLD, not SWRST.
  - sw_reset_req in FILTER is ignored, so the release timing is unchanged.
- Reset mid-RELEASE: assert `reset` for one cycle.
  - All outputs return to their reset values next edge.
  - Full resequencing from HOLD after the sync-chain refill.
- Saturation: 300 forced glitches → glitch_cnt holds at 255.
